// File: rtl/lcd_pkg.sv
// lcd_pkg: character constants and blank-line helper shared by the line history blocks
package lcd_pkg;
   localparam int CHAR_W = 8;
   localparam logic [CHAR_W-1:0] BLANK_CHAR = 8'h20;
   localparam int MAX_CHARS = 64;
   function automatic logic [MAX_CHARS*CHAR_W-1:0] blank_line(int chars);
      logic [MAX_CHARS*CHAR_W-1:0] l;
      l = '0;
      for (int i = 0; i < MAX_CHARS; i++)
         if (i < chars) l[i*CHAR_W +: CHAR_W] = BLANK_CHAR;
      return l;
   endfunction
endpackage

// File: rtl/lcd_row_select.sv
// lcd_row_select: maps the scrolled view onto stored lines, blanking rows past the valid history
//   wr_ptr, line_count, view_off, mem in; rows out (row 0 in the top LW bits, newest visible line)
module lcd_row_select
   import lcd_pkg::*;
#(
   parameter int CHARS = 20,
   parameter int ROWS  = 4,
   parameter int DEPTH = 16
) (
   input  logic [$clog2(DEPTH)-1:0]               wr_ptr,
   input  logic [$clog2(DEPTH+1)-1:0]             line_count,
   input  logic [$clog2(DEPTH)-1:0]               view_off,
   input  logic [DEPTH-1:0][CHAR_W*CHARS-1:0]     mem,
   output logic [CHAR_W*CHARS*ROWS-1:0]           rows
);
   localparam int LW = CHAR_W*CHARS;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [LW-1:0] BLANK = LW'(blank_line(CHARS));
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [CW-1:0] k;
      assign k = CW'(view_off) + CW'(r);
      // k counts back from the newest line; index wraps mod DEPTH in AW bits
      assign rows[LW*(ROWS-r)-1 -: LW] = (k < line_count) ? mem[wr_ptr - AW'(1) - k[AW-1:0]] : BLANK;
   end
endmodule

// File: rtl/lcd_line_history.sv
// lcd_line_history: circular history of saved LCD lines with a scrollable ROWS-line window
//   ckht/rst clock and sync reset; save_tick captures lcd_data; clear empties history;
//   up_tick/down_tick scroll; lcd_rows/at_newest/at_oldest registered view; refresh marks new content;
//   line_count/view_off expose state directly
module lcd_line_history
   import lcd_pkg::*;
#(
   parameter int CHARS  = 20,
   parameter int ROWS   = 4,
   parameter int DEPTH  = 16,
   parameter int FOLLOW = 1
) (
   input  logic                            ckht,
   input  logic                            rst,
   input  logic                            save_tick,
   input  logic                            clear,
   input  logic                            up_tick,
   input  logic                            down_tick,
   input  logic [CHAR_W*CHARS-1:0]         lcd_data,
   output logic [CHAR_W*CHARS*ROWS-1:0]    lcd_rows,
   output logic [$clog2(DEPTH+1)-1:0]      line_count,
   output logic [$clog2(DEPTH)-1:0]        view_off,
   output logic                            at_newest,
   output logic                            at_oldest,
   output logic                            refresh
);
   localparam int LW = CHAR_W*CHARS;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [LW-1:0] BLANK = LW'(blank_line(CHARS));
   logic [DEPTH-1:0][LW-1:0] mem;
   logic [AW-1:0]            wr_ptr;
   logic [LW*ROWS-1:0]       rows_sel;
   logic [CW-1:0]            lc_new, vo_inc, vo_cap, vo_save;
   logic                     can_up, do_up, do_down, pend;
   assign lc_new  = (line_count == CW'(DEPTH)) ? line_count : line_count + CW'(1);
   assign vo_inc  = CW'(view_off) + CW'(1);
   assign vo_cap  = (lc_new > CW'(ROWS)) ? lc_new - CW'(ROWS) : '0;
   // hold mode pushes the view back by one so the displayed lines stay put
   assign vo_save = (FOLLOW != 0 || view_off == '0) ? '0 : (vo_inc < vo_cap ? vo_inc : vo_cap);
   assign can_up  = CW'(view_off) + CW'(ROWS) < line_count;
   assign do_up   = up_tick & ~down_tick & can_up;
   assign do_down = down_tick & ~up_tick & (view_off != '0);
   lcd_row_select #(.CHARS(CHARS), .ROWS(ROWS), .DEPTH(DEPTH)) u_sel (
      .wr_ptr(wr_ptr), .line_count(line_count), .view_off(view_off), .mem(mem), .rows(rows_sel)
   );
   always_ff @(posedge ckht)
      if (!rst && !clear && save_tick) mem[wr_ptr] <= lcd_data;
   always_ff @(posedge ckht) begin
      if (rst) begin
         wr_ptr     <= '0;
         line_count <= '0;
         view_off   <= '0;
         pend       <= 1'b0;
         refresh    <= 1'b0;
         lcd_rows   <= {ROWS{BLANK}};
         at_newest  <= 1'b1;
         at_oldest  <= 1'b1;
      end else begin
         refresh   <= pend;
         lcd_rows  <= rows_sel;
         at_newest <= view_off == '0;
         at_oldest <= !can_up;
         if (clear) begin
            wr_ptr     <= '0;
            line_count <= '0;
            view_off   <= '0;
            pend       <= 1'b1;
         end else if (save_tick) begin
            wr_ptr     <= wr_ptr + AW'(1);
            line_count <= lc_new;
            view_off   <= AW'(vo_save);
            pend       <= 1'b1;
         end else begin
            view_off <= do_up ? view_off + AW'(1) : do_down ? view_off - AW'(1) : view_off;
            pend     <= do_up | do_down;
         end
      end
   end
endmodule

// File: tb/tb_lcd_line_history.sv
// tb_lcd_line_history: directed and random checks of two instances (follow and hold) against a queue model
module tb_lcd_line_history;
   localparam int CHARS = 20;
   localparam int ROWS  = 4;
   localparam int DEPTH = 8;
   localparam int LW    = 8*CHARS;
   localparam int RW    = LW*ROWS;
   logic ckht = 0, rst = 1, save_tick = 0, clear = 0, up_tick = 0, down_tick = 0;
   logic [LW-1:0] lcd_data = '0;
   logic [RW-1:0] rows_o [2];
   logic [3:0]    lc_o [2];
   logic [2:0]    vo_o [2];
   logic          new_o [2], old_o [2], ref_o [2];
   int checks = 0, errors = 0;
   logic [LW-1:0] hist [$];
   int vo [2];
   bit ref_e [2];
   always #5 ckht = ~ckht;
   lcd_line_history #(.CHARS(CHARS), .ROWS(ROWS), .DEPTH(DEPTH), .FOLLOW(0)) dut0 (
      .ckht(ckht), .rst(rst), .save_tick(save_tick), .clear(clear), .up_tick(up_tick),
      .down_tick(down_tick), .lcd_data(lcd_data), .lcd_rows(rows_o[0]), .line_count(lc_o[0]),
      .view_off(vo_o[0]), .at_newest(new_o[0]), .at_oldest(old_o[0]), .refresh(ref_o[0]));
   lcd_line_history #(.CHARS(CHARS), .ROWS(ROWS), .DEPTH(DEPTH), .FOLLOW(1)) dut1 (
      .ckht(ckht), .rst(rst), .save_tick(save_tick), .clear(clear), .up_tick(up_tick),
      .down_tick(down_tick), .lcd_data(lcd_data), .lcd_rows(rows_o[1]), .line_count(lc_o[1]),
      .view_off(vo_o[1]), .at_newest(new_o[1]), .at_oldest(old_o[1]), .refresh(ref_o[1]));
   function automatic logic [LW-1:0] fill(logic [7:0] ch);
      return {CHARS{ch}};
   endfunction
   function automatic logic [RW-1:0] want(int v);
      logic [RW-1:0] w;
      for (int r = 0; r < ROWS; r++)
         w[RW-1-r*LW -: LW] = (v + r < hist.size()) ? hist[v+r] : fill(8'h20);
      return w;
   endfunction
   task automatic chk(string tag, int f, logic [RW-1:0] obs, logic [RW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[follow=%0d] observed=%h expected=%h", tag, f, obs, exp);
      end
   endtask
   task automatic apply(bit r, bit s, bit c, bit u, bit d, logic [LW-1:0] data);
      rst = r; save_tick = s; clear = c; up_tick = u; down_tick = d; lcd_data = data;
      @(posedge ckht); #1;
      rst = 0; save_tick = 0; clear = 0; up_tick = 0; down_tick = 0;
      if (r || c) begin
         hist.delete();
         vo[0] = 0; vo[1] = 0;
         ref_e[0] = !r; ref_e[1] = !r;
      end else if (s) begin
         hist.push_front(data);
         if (hist.size() > DEPTH) void'(hist.pop_back());
         vo[1] = 0;
         if (vo[0] != 0) begin
            int cap;
            cap = hist.size() > ROWS ? hist.size() - ROWS : 0;
            vo[0] = vo[0] + 1 < cap ? vo[0] + 1 : cap;
         end
         ref_e[0] = 1; ref_e[1] = 1;
      end else begin
         for (int f = 0; f < 2; f++) begin
            ref_e[f] = 0;
            if (u && !d && vo[f] + ROWS < hist.size()) begin vo[f]++; ref_e[f] = 1; end
            else if (d && !u && vo[f] > 0) begin vo[f]--; ref_e[f] = 1; end
         end
      end
   endtask
   task automatic check_state();
      for (int f = 0; f < 2; f++) begin
         chk("line_count", f, RW'(lc_o[f]), RW'(hist.size()));
         chk("view_off", f, RW'(vo_o[f]), RW'(vo[f]));
      end
   endtask
   task automatic check_out();
      @(posedge ckht); #1;
      for (int f = 0; f < 2; f++) begin
         chk("lcd_rows", f, rows_o[f], want(vo[f]));
         chk("at_newest", f, RW'(new_o[f]), RW'(vo[f] == 0));
         chk("at_oldest", f, RW'(old_o[f]), RW'(vo[f] + ROWS >= hist.size()));
         chk("refresh", f, RW'(ref_o[f]), RW'(ref_e[f]));
      end
   endtask
   task automatic step(bit r, bit s, bit c, bit u, bit d, logic [LW-1:0] data);
      apply(r, s, c, u, d, data);
      check_state();
      check_out();
   endtask
   initial begin
      repeat (2) @(posedge ckht);
      #1;
      step(1, 0, 0, 0, 0, '0);
      step(0, 1, 0, 0, 0, fill("A"));
      step(0, 0, 1, 0, 0, '0);
      for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, fill(8'(48 + i)));
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, '0);
      step(0, 0, 1, 0, 0, '0);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, fill(8'(97 + i)));
      step(0, 0, 0, 1, 0, '0);
      step(0, 0, 0, 1, 0, '0);
      step(0, 1, 0, 0, 0, fill("X"));
      step(0, 0, 0, 1, 1, '0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, '0);
      step(0, 1, 1, 0, 0, fill("Q"));
      step(0, 1, 0, 0, 0, fill("R"));
      step(1, 1, 0, 0, 0, fill("S"));
      for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0, fill(8'(65 + i)));
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, '0);
      for (int i = 0; i < 11; i++) apply(0, 1, 0, 0, 0, fill(8'(48 + i)));
      check_state();
      check_out();
      for (int i = 0; i < 300; i++) begin
         logic [LW-1:0] data;
         data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
              1'($urandom), 1'($urandom), data);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
